cgra_fabric: RTL and testbench

Single-tile coarse-grained reconfigurable fabric top. It receives 16-bit words on three pad sides (S0, S1, S2), processes them through one configurable 16-bit PE, and drives the result onto the S0 output pads. The PE is programmed through a flat address/data configuration bus. The block is the chip-level top seen by the system testbench; the JTAG pins are present but inert.

---
 rtl/cgra_pkg.sv | 48 ++++
 rtl/cgra_fabric_pe_alu.sv | 26 ++
 rtl/cgra_fabric.sv | 123 ++++++++++++
 tb/tb_cgra_fabric.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// cgra_pkg: shared types, register map and helpers for the single-tile CGRA.
package cgra_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    OP_PASS = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    SRC_S0    = 2'd0,
    SRC_S1    = 2'd1,
    SRC_S2    = 2'd2,
    SRC_CONST = 2'd3
  } src_e;

  localparam logic [31:0] ADDR_OP       = 32'h1;
  localparam logic [31:0] ADDR_SRC_A    = 32'h2;
  localparam logic [31:0] ADDR_SRC_B    = 32'h3;
  localparam logic [31:0] ADDR_CONST    = 32'h4;
  localparam logic [31:0] ADDR_OUT_CTRL = 32'h5;

  function automatic word_t sel_src(
    input src_e  sel,
    input word_t s0,
    input word_t s1,
    input word_t s2,
    input word_t k
  );
    case (sel)
      SRC_S0:  return s0;
      SRC_S1:  return s1;
      SRC_S2:  return s2;
      default: return k;
    endcase
  endfunction

endpackage

// File: rtl/cgra_fabric_pe_alu.sv
// pe_alu: combinational 16-bit PE datapath, modulo-2^16 results.
import cgra_pkg::*;

module pe_alu (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [3:0]        op,
  output logic [WORD_W-1:0] res
);

  always_comb begin
    res = a;
    case (op_e'(op))
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_MUL:  res = a * b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL:  res = a << b[3:0];
      OP_SHR:  res = a >> b[3:0];
      default: res = a;
    endcase
  end

endmodule

// File: rtl/cgra_fabric.sv
// cgra_fabric: chip top with pad packing, config registers, one PE and
// an optional output register driving side S0.
import cgra_pkg::*;

module cgra_fabric (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [31:0] config_addr_in,
  input  logic [31:0] config_data_in,
  input  logic pad_S0_T0_in,  input  logic pad_S0_T1_in,
  input  logic pad_S0_T2_in,  input  logic pad_S0_T3_in,
  input  logic pad_S0_T4_in,  input  logic pad_S0_T5_in,
  input  logic pad_S0_T6_in,  input  logic pad_S0_T7_in,
  input  logic pad_S0_T8_in,  input  logic pad_S0_T9_in,
  input  logic pad_S0_T10_in, input  logic pad_S0_T11_in,
  input  logic pad_S0_T12_in, input  logic pad_S0_T13_in,
  input  logic pad_S0_T14_in, input  logic pad_S0_T15_in,
  input  logic pad_S1_T0_in,  input  logic pad_S1_T1_in,
  input  logic pad_S1_T2_in,  input  logic pad_S1_T3_in,
  input  logic pad_S1_T4_in,  input  logic pad_S1_T5_in,
  input  logic pad_S1_T6_in,  input  logic pad_S1_T7_in,
  input  logic pad_S1_T8_in,  input  logic pad_S1_T9_in,
  input  logic pad_S1_T10_in, input  logic pad_S1_T11_in,
  input  logic pad_S1_T12_in, input  logic pad_S1_T13_in,
  input  logic pad_S1_T14_in, input  logic pad_S1_T15_in,
  input  logic pad_S2_T0_in,  input  logic pad_S2_T1_in,
  input  logic pad_S2_T2_in,  input  logic pad_S2_T3_in,
  input  logic pad_S2_T4_in,  input  logic pad_S2_T5_in,
  input  logic pad_S2_T6_in,  input  logic pad_S2_T7_in,
  input  logic pad_S2_T8_in,  input  logic pad_S2_T9_in,
  input  logic pad_S2_T10_in, input  logic pad_S2_T11_in,
  input  logic pad_S2_T12_in, input  logic pad_S2_T13_in,
  input  logic pad_S2_T14_in, input  logic pad_S2_T15_in,
  output logic pad_S0_T0_out,  output logic pad_S0_T1_out,
  output logic pad_S0_T2_out,  output logic pad_S0_T3_out,
  output logic pad_S0_T4_out,  output logic pad_S0_T5_out,
  output logic pad_S0_T6_out,  output logic pad_S0_T7_out,
  output logic pad_S0_T8_out,  output logic pad_S0_T9_out,
  output logic pad_S0_T10_out, output logic pad_S0_T11_out,
  output logic pad_S0_T12_out, output logic pad_S0_T13_out,
  output logic pad_S0_T14_out, output logic pad_S0_T15_out,
  input  logic tdi,
  input  logic tms,
  input  logic tck,
  input  logic trst_n,
  output logic tdo
);

  word_t s0, s1, s2;
  word_t a, b, res, res_q, out_w;

  logic [3:0] op_q;
  src_e       src_a_q, src_b_q;
  word_t      const_q;
  logic       out_en_q, out_reg_q;

  // T0 is the MSB on every side
  assign s0 = {pad_S0_T0_in,  pad_S0_T1_in,  pad_S0_T2_in,  pad_S0_T3_in,
               pad_S0_T4_in,  pad_S0_T5_in,  pad_S0_T6_in,  pad_S0_T7_in,
               pad_S0_T8_in,  pad_S0_T9_in,  pad_S0_T10_in, pad_S0_T11_in,
               pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in};
  assign s1 = {pad_S1_T0_in,  pad_S1_T1_in,  pad_S1_T2_in,  pad_S1_T3_in,
               pad_S1_T4_in,  pad_S1_T5_in,  pad_S1_T6_in,  pad_S1_T7_in,
               pad_S1_T8_in,  pad_S1_T9_in,  pad_S1_T10_in, pad_S1_T11_in,
               pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in};
  assign s2 = {pad_S2_T0_in,  pad_S2_T1_in,  pad_S2_T2_in,  pad_S2_T3_in,
               pad_S2_T4_in,  pad_S2_T5_in,  pad_S2_T6_in,  pad_S2_T7_in,
               pad_S2_T8_in,  pad_S2_T9_in,  pad_S2_T10_in, pad_S2_T11_in,
               pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in};

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      op_q      <= 4'd0;
      src_a_q   <= SRC_S0;
      src_b_q   <= SRC_S0;
      const_q   <= '0;
      out_en_q  <= 1'b0;
      out_reg_q <= 1'b0;
    end else begin
      case (config_addr_in)
        ADDR_OP:       op_q    <= config_data_in[3:0];
        ADDR_SRC_A:    src_a_q <= src_e'(config_data_in[1:0]);
        ADDR_SRC_B:    src_b_q <= src_e'(config_data_in[1:0]);
        ADDR_CONST:    const_q <= config_data_in[WORD_W-1:0];
        ADDR_OUT_CTRL: begin
          out_en_q  <= config_data_in[0];
          out_reg_q <= config_data_in[1];
        end
        default: ;
      endcase
    end
  end

  assign a = sel_src(src_a_q, s0, s1, s2, const_q);
  assign b = sel_src(src_b_q, s0, s1, s2, const_q);

  pe_alu u_pe_alu (
    .a   (a),
    .b   (b),
    .op  (op_q),
    .res (res)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) res_q <= '0;
    else          res_q <= res;
  end

  assign out_w = !out_en_q ? '0 : (out_reg_q ? res_q : res);

  assign {pad_S0_T0_out,  pad_S0_T1_out,  pad_S0_T2_out,  pad_S0_T3_out,
          pad_S0_T4_out,  pad_S0_T5_out,  pad_S0_T6_out,  pad_S0_T7_out,
          pad_S0_T8_out,  pad_S0_T9_out,  pad_S0_T10_out, pad_S0_T11_out,
          pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out}
    = out_w;

  assign tdo = 1'b0;

  // JTAG is inert and the upper config data bits have no destination
  logic unused_ok;
  assign unused_ok = ^{tdi, tms, tck, trst_n, config_data_in[31:16]};

endmodule

// File: tb/tb_cgra_fabric.sv
// tb_cgra_fabric: directed vectors with hand-computed results for the
// single-tile fabric; outputs sampled just after the falling edge.
module tb_cgra_fabric;

  logic        clk_in;
  logic        reset_in;
  logic [31:0] config_addr_in;
  logic [31:0] config_data_in;
  logic [15:0] s0, s1, s2;
  wire  [15:0] o;
  logic        tdi, tms, tck, trst_n;
  wire         tdo;

  int n_vec;
  int n_bad;

  cgra_fabric dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .config_addr_in (config_addr_in),
    .config_data_in (config_data_in),
    .pad_S0_T0_in (s0[15]), .pad_S0_T1_in (s0[14]),
    .pad_S0_T2_in (s0[13]), .pad_S0_T3_in (s0[12]),
    .pad_S0_T4_in (s0[11]), .pad_S0_T5_in (s0[10]),
    .pad_S0_T6_in (s0[9]),  .pad_S0_T7_in (s0[8]),
    .pad_S0_T8_in (s0[7]),  .pad_S0_T9_in (s0[6]),
    .pad_S0_T10_in(s0[5]),  .pad_S0_T11_in(s0[4]),
    .pad_S0_T12_in(s0[3]),  .pad_S0_T13_in(s0[2]),
    .pad_S0_T14_in(s0[1]),  .pad_S0_T15_in(s0[0]),
    .pad_S1_T0_in (s1[15]), .pad_S1_T1_in (s1[14]),
    .pad_S1_T2_in (s1[13]), .pad_S1_T3_in (s1[12]),
    .pad_S1_T4_in (s1[11]), .pad_S1_T5_in (s1[10]),
    .pad_S1_T6_in (s1[9]),  .pad_S1_T7_in (s1[8]),
    .pad_S1_T8_in (s1[7]),  .pad_S1_T9_in (s1[6]),
    .pad_S1_T10_in(s1[5]),  .pad_S1_T11_in(s1[4]),
    .pad_S1_T12_in(s1[3]),  .pad_S1_T13_in(s1[2]),
    .pad_S1_T14_in(s1[1]),  .pad_S1_T15_in(s1[0]),
    .pad_S2_T0_in (s2[15]), .pad_S2_T1_in (s2[14]),
    .pad_S2_T2_in (s2[13]), .pad_S2_T3_in (s2[12]),
    .pad_S2_T4_in (s2[11]), .pad_S2_T5_in (s2[10]),
    .pad_S2_T6_in (s2[9]),  .pad_S2_T7_in (s2[8]),
    .pad_S2_T8_in (s2[7]),  .pad_S2_T9_in (s2[6]),
    .pad_S2_T10_in(s2[5]),  .pad_S2_T11_in(s2[4]),
    .pad_S2_T12_in(s2[3]),  .pad_S2_T13_in(s2[2]),
    .pad_S2_T14_in(s2[1]),  .pad_S2_T15_in(s2[0]),
    .pad_S0_T0_out (o[15]), .pad_S0_T1_out (o[14]),
    .pad_S0_T2_out (o[13]), .pad_S0_T3_out (o[12]),
    .pad_S0_T4_out (o[11]), .pad_S0_T5_out (o[10]),
    .pad_S0_T6_out (o[9]),  .pad_S0_T7_out (o[8]),
    .pad_S0_T8_out (o[7]),  .pad_S0_T9_out (o[6]),
    .pad_S0_T10_out(o[5]),  .pad_S0_T11_out(o[4]),
    .pad_S0_T12_out(o[3]),  .pad_S0_T13_out(o[2]),
    .pad_S0_T14_out(o[1]),  .pad_S0_T15_out(o[0]),
    .tdi    (tdi),
    .tms    (tms),
    .tck    (tck),
    .trst_n (trst_n),
    .tdo    (tdo)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // one write, captured on the next rising edge; returns at the falling edge
  task automatic cfg(input logic [31:0] addr, input logic [31:0] data);
    config_addr_in = addr;
    config_data_in = data;
    @(negedge clk_in);
    config_addr_in = '0;
    config_data_in = '0;
  endtask

  task automatic prog_double();
    cfg(32'h1, 32'd3);
    cfg(32'h2, 32'd2);
    cfg(32'h3, 32'd3);
    cfg(32'h4, 32'd2);
    cfg(32'h5, 32'd1);
  endtask

  // {op, a, b, expected}, A from S0, B from S1
  localparam int NOPS = 17;
  logic [51:0] ops [NOPS] = '{
    {4'd0,  16'h1234, 16'h0003, 16'h1234},
    {4'd1,  16'h1234, 16'h0003, 16'h1237},
    {4'd1,  16'hFFFF, 16'h0001, 16'h0000},
    {4'd2,  16'h1234, 16'h0003, 16'h1231},
    {4'd2,  16'h0003, 16'h0005, 16'hFFFE},
    {4'd3,  16'h1234, 16'h0003, 16'h369C},
    {4'd3,  16'hFFFF, 16'hFFFF, 16'h0001},
    {4'd4,  16'hFF00, 16'h0FF0, 16'h0F00},
    {4'd5,  16'hFF00, 16'h0FF0, 16'hFFF0},
    {4'd6,  16'hFF00, 16'h0FF0, 16'hF0F0},
    {4'd7,  16'h1234, 16'h0003, 16'h91A0},
    {4'd7,  16'h1234, 16'h0010, 16'h1234},
    {4'd8,  16'h1234, 16'h0003, 16'h0246},
    {4'd8,  16'h8000, 16'h000F, 16'h0001},
    {4'd8,  16'hABCD, 16'hFFF0, 16'hABCD},
    {4'd9,  16'h1234, 16'h0003, 16'h1234},
    {4'd15, 16'hBEEF, 16'h0003, 16'hBEEF}
  };

  initial begin
    logic [51:0] v;
    logic [15:0] cnt;
    n_vec = 0;
    n_bad = 0;
    reset_in = 1'b1;
    config_addr_in = '0;
    config_data_in = '0;
    tdi = 1'b0; tms = 1'b0; tck = 1'b0; trst_n = 1'b1;
    s0 = 16'hA5A5;
    s1 = 16'h5A5A;
    s2 = 16'hFFFF;

    @(negedge clk_in);
    @(negedge clk_in);
    #1;
    check("reset_out", o, 16'h0000);
    check("reset_tdo", {15'd0, tdo}, 16'h0000);
    @(negedge clk_in);
    reset_in = 1'b0;

    prog_double();
    s2 = 16'h1234;
    #1 check("dbl_1234", o, 16'h2468);
    s2 = 16'h8001;
    #1 check("dbl_8001", o, 16'h0002);
    check("tdo_idle", {15'd0, tdo}, 16'h0000);

    // address 0 carries data but must not write; 0x99 is unmapped
    @(negedge clk_in);
    config_addr_in = 32'h0;
    config_data_in = 32'hFFFF_FFFF;
    @(negedge clk_in);
    config_addr_in = 32'h99;
    @(negedge clk_in);
    config_addr_in = '0;
    config_data_in = '0;
    #1 check("addr0_unmap_a", o, 16'h0002);
    s2 = 16'h1234;
    #1 check("addr0_unmap_b", o, 16'h2468);

    // shift-by-const, counter on S2 wrapping through 0xFFFF
    @(negedge clk_in);
    cfg(32'h1, 32'd7);
    cfg(32'h4, 32'd1);
    cnt = 16'hFE00;
    for (int i = 0; i < 1000; i++) begin
      s2 = cnt;
      #1 check("shl_cnt", o, {cnt[14:0], 1'b0});
      @(negedge clk_in);
      cnt = cnt + 16'd1;
    end

    // ALU table with A=S0, B=S1
    cfg(32'h2, 32'd0);
    cfg(32'h3, 32'd1);
    for (int i = 0; i < NOPS; i++) begin
      v = ops[i];
      cfg(32'h1, {28'd0, v[51:48]});
      s0 = v[47:32];
      s1 = v[31:16];
      #1 check($sformatf("op%0d_%0d", v[51:48], i), o, v[15:0]);
    end

    cfg(32'h5, 32'd0);
    #1 check("out_en_off", o, 16'h0000);

    // registered mode: pads idle while enabling so the register holds 0
    s0 = 16'h0000;
    s1 = 16'h0000;
    cfg(32'h1, 32'd1);
    cfg(32'h5, 32'd3);
    s0 = 16'h0003;
    s1 = 16'h0005;
    #1 check("reg_first", o, 16'h0000);
    @(negedge clk_in);
    #1 check("reg_add", o, 16'h0008);
    s1 = 16'h0007;
    #1 check("reg_hold", o, 16'h0008);
    @(negedge clk_in);
    #1 check("reg_add2", o, 16'h000A);

    // asynchronous reset mid-cycle while doubling is active
    @(negedge clk_in);
    prog_double();
    s2 = 16'h1234;
    #1 check("pre_rst", o, 16'h2468);
    #2 reset_in = 1'b1;
    #1 check("rst_async", o, 16'h0000);
    @(negedge clk_in);
    reset_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    #1 check("rst_cfg_lost", o, 16'h0000);
    @(negedge clk_in);
    prog_double();
    #1 check("reprog", o, 16'h2468);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
